schedule_multi: RTL and testbench
=================================

Name: schedule_multi

Overview:
- Parametrised successor of the single-issue scheduler.
- Accepts one decoded instruction per cycle and checks operand and destination hazards against a register scoreboard.
- Issues the instruction to a free unit from a configurable ALU pool, or to the advint, memunit or branch unit.
- Sits between decode and the execution units. Clears scoreboard entries from NUM_WB write-back ports and supports a pipeline flush.

Parameters:
- REG_BITS, 6: register-number width; register file has 2**REG_BITS entries, r0 hard-wired zero.
- NUM_ALU, 2: number of ALU instances, 1..8.
- NUM_WB, 2: number of write-back (register finished) ports, 1..4.
- STARTUP_STALL, 2: cycles after reset release during which nothing issues, 1..15.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decoded instruction present.
- in_class  in  2  unit class: 0 ALU, 1 ADVINT, 2 MEM, 3 BRANCH.
- in_nodest  in  1  instruction writes no register (store); rd is not marked busy.
- r1_in_rn, r2_in_rn  in  REG_BITS  source registers.
- rd_in_rn, rd2_in_rn  in  REG_BITS  destinations; rd2 is used only by ADVINT.
- will_issue  out  1  combinational; instruction accepted this cycle.
- wb_rn  in  NUM_WB*REG_BITS  finished register numbers, port i at bits [i*REG_BITS +: REG_BITS].
- wb_valid  in  NUM_WB  per-port finished strobe.
- flush  in  1  squash the current decode slot.
- alu_en  out  NUM_ALU  one-hot, registered.
- advint_en, memunit_en, branch_en  out  1  registered enables.
- alu_busy  in  NUM_ALU  per-ALU busy.
- advint_busy, memunit_busy, branch_busy  in  1  unit busy.
- rd_out_rn, rd2_out_rn  out  REG_BITS  registered destinations, valid with the enables.
- busy_count  out  REG_BITS+1  registered count of busy scoreboard entries.

Behaviour:
- Reset: all enables 0, rd_out_rn/rd2_out_rn 0, scoreboard all 0, busy_count 0, startup counter loaded with STARTUP_STALL, RR pointer 0.
- Startup: will_issue forced 0 while startup counter is non-zero. It decrements each cycle after reset.
- Effective busy: busy_eff[r] = sb[r] & ~(any valid wb port equals r). This gives same-cycle write-back bypass. r0 is never busy.
- Hazard stall conditions:
  - busy_eff[r1] or busy_eff[r2] (RAW).
  - busy_eff[rd], or busy_eff[rd2] for ADVINT (WAW).
- will_issue = in_valid & ~flush & ~startup & ~hazard & target unit free.
  - ALU: any alu_busy bit low.
  - ADVINT requires ~advint_busy; MEM requires ~memunit_busy; BRANCH requires ~branch_busy.
- Issue latency: exactly 1 cycle. On the edge where will_issue=1, the selected enable goes high for one cycle with rd_out_rn=rd_in_rn. rd2_out_rn=rd2_in_rn for ADVINT, 0 otherwise. Otherwise all enables and rd outputs return to 0.
- ALU select: lowest-index free ALU (see optional feature).
- Scoreboard update each edge:
  - Clear all valid wb ports.
  - Then set rd (if non-zero and not in_nodest) and rd2 (ADVINT, non-zero) on issue.
  - Set wins over a same-cycle clear of the same register.
  - Duplicate wb numbers are harmless.
- busy_count equals the popcount of the next scoreboard value.
- flush: blocks issue this cycle only; the scoreboard is kept, because in-flight ops still write back.
- rst asserted mid-operation: all state returns to reset values on that edge and the startup stall restarts.

Optional Feature:
- SCHED_RR_EN defined: ALU selection is round-robin.
  - Search starts at the ALU after the last one issued and wraps modulo NUM_ALU.
  - Pointer updates only on ALU issue.
- SCHED_RR_EN undefined: fixed priority, lowest free index; no pointer register.

Decomposition:
- Package sched_pkg:
  - Class encodings SCHED_CLASS_ALU/ADVINT/MEM/BRANCH.
  - Class width constant.
  - Default REG_BITS.
- Sub-module sched_scoreboard (params REG_BITS, NUM_WB):
  - Holds the busy vector.
  - Provides wb clear, two set ports with set-priority, a busy_eff lookup for four read ports, and busy_count.
- schedule_multi keeps the startup counter, hazard/select logic and output registers.

Test Plan:
- Startup: release rst, ALU op r1=1 r2=2 rd=3 valid from cycle 0 -> will_issue=0 for 2 cycles, alu_en=01 on the following edge, rd_out_rn=3, busy_count=1.
- RAW + bypass:
  - Issue rd=5, then present r1=5 -> stalls.
  - Pulse wb_rn[0]=5 -> will_issue=1 that same cycle; issue next edge; busy_count returns 1 (new rd) or 0 if rd=0.
- Set-over-clear: wb port 1 = 7 in the same cycle an op with rd=7 issues -> sb[7]=1 afterwards, and a later r1=7 stalls.
- ALU pool, NUM_ALU=3, alu_busy=001:
  - Fixed mode: three back-to-back ALU ops -> alu_en sequence 010, 010, 010.
  - SCHED_RR_EN with alu_busy=000: sequence 001, 010, 100, 001.
- ADVINT dual-dest and store:
  - ADVINT rd=10 rd2=11 -> both busy, rd2_out_rn=11.
  - MEM with in_nodest, rd=12 -> memunit_en=1, sb[12] stays 0.
- Flush/reset: flush=1 with a legal op -> no enable, scoreboard unchanged. rst mid-stream with 4 busy regs -> busy_count=0 next cycle, and the 2-cycle stall repeats.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared encodings and defaults for the multi-issue scheduler slice.
package sched_pkg;

  localparam int SCHED_CLASS_W      = 2;
  localparam int SCHED_DEF_REG_BITS = 6;

  typedef enum logic [SCHED_CLASS_W-1:0] {
    SCHED_CLASS_ALU    = 2'd0,
    SCHED_CLASS_ADVINT = 2'd1,
    SCHED_CLASS_MEM    = 2'd2,
    SCHED_CLASS_BRANCH = 2'd3
  } sched_class_e;

endpackage

// File: rtl/sched_scoreboard.sv
// Register busy scoreboard: write-back clears, two set ports that win over
// clears, four bypassed busy lookups and a registered busy-entry count.
module sched_scoreboard
  import sched_pkg::*;
#(
  parameter int REG_BITS = SCHED_DEF_REG_BITS,
  parameter int NUM_WB   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_WB*REG_BITS-1:0] i_wbRn,
  input  logic [NUM_WB-1:0]          i_wbValid,
  input  logic                       i_set0En,
  input  logic [REG_BITS-1:0]        i_set0Rn,
  input  logic                       i_set1En,
  input  logic [REG_BITS-1:0]        i_set1Rn,
  input  logic [3:0][REG_BITS-1:0]   i_readRn,
  output logic [3:0]                 o_busyEff,
  output logic [REG_BITS:0]          o_busyCount
);

  localparam int NUM_REGS = 1 << REG_BITS;

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_wbHit;
  logic [NUM_REGS-1:0] w_busyNext;
  logic [REG_BITS:0]   w_countNext;
  logic [REG_BITS:0]   r_busyCount;

  always_comb begin
    w_wbHit = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (i_wbValid[i]) begin
        w_wbHit[i_wbRn[i*REG_BITS +: REG_BITS]] = 1'b1;
      end
    end
  end

  // Sets are applied after clears so a register re-allocated in the same
  // cycle it finishes stays busy for the new producer.
  always_comb begin
    w_busyNext = r_busy & ~w_wbHit;
    if (i_set0En) begin
      w_busyNext[i_set0Rn] = 1'b1;
    end
    if (i_set1En) begin
      w_busyNext[i_set1Rn] = 1'b1;
    end
    w_busyNext[0] = 1'b0;
  end

  always_comb begin
    w_countNext = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_countNext = w_countNext + {{REG_BITS{1'b0}}, w_busyNext[i]};
    end
  end

  always_comb begin
    o_busyEff = '0;
    for (int p = 0; p < 4; p++) begin
      o_busyEff[p] = r_busy[i_readRn[p]] & ~w_wbHit[i_readRn[p]] &
                     (i_readRn[p] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= '0;
      r_busyCount <= '0;
    end else begin
      r_busy      <= w_busyNext;
      r_busyCount <= w_countNext;
    end
  end

  assign o_busyCount = r_busyCount;

endmodule

// File: rtl/schedule_multi.sv
// Multi-unit instruction scheduler with scoreboard hazard checks.
// Define SCHED_RR_EN for round-robin ALU selection (default: lowest free ALU).
module schedule_multi
  import sched_pkg::*;
#(
  parameter int REG_BITS      = SCHED_DEF_REG_BITS,
  parameter int NUM_ALU       = 2,
  parameter int NUM_WB        = 2,
  parameter int STARTUP_STALL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [SCHED_CLASS_W-1:0]   in_class,
  input  logic                       in_nodest,
  input  logic [REG_BITS-1:0]        r1_in_rn,
  input  logic [REG_BITS-1:0]        r2_in_rn,
  input  logic [REG_BITS-1:0]        rd_in_rn,
  input  logic [REG_BITS-1:0]        rd2_in_rn,
  output logic                       will_issue,
  input  logic [NUM_WB*REG_BITS-1:0] wb_rn,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic                       flush,
  output logic [NUM_ALU-1:0]         alu_en,
  output logic                       advint_en,
  output logic                       memunit_en,
  output logic                       branch_en,
  input  logic [NUM_ALU-1:0]         alu_busy,
  input  logic                       advint_busy,
  input  logic                       memunit_busy,
  input  logic                       branch_busy,
  output logic [REG_BITS-1:0]        rd_out_rn,
  output logic [REG_BITS-1:0]        rd2_out_rn,
  output logic [REG_BITS:0]          busy_count
);

  sched_class_e             w_class;
  logic                     w_isAlu;
  logic                     w_isAdv;
  logic                     w_isMem;
  logic                     w_isBr;
  logic                     w_unitFree;
  logic                     w_hazard;
  logic                     w_startup;
  logic                     w_willIssue;
  logic [3:0]               w_busyEff;
  logic [3:0][REG_BITS-1:0] w_readRn;
  logic [NUM_ALU-1:0]       w_aluSel;
  logic [3:0]               r_startCnt;
  logic [NUM_ALU-1:0]       r_aluEn;
  logic                     r_advEn;
  logic                     r_memEn;
  logic                     r_brEn;
  logic [REG_BITS-1:0]      r_rdOut;
  logic [REG_BITS-1:0]      r_rd2Out;

  assign w_class = sched_class_e'(in_class);
  assign w_isAlu = (w_class == SCHED_CLASS_ALU);
  assign w_isAdv = (w_class == SCHED_CLASS_ADVINT);
  assign w_isMem = (w_class == SCHED_CLASS_MEM);
  assign w_isBr  = (w_class == SCHED_CLASS_BRANCH);

  assign w_readRn[0] = r1_in_rn;
  assign w_readRn[1] = r2_in_rn;
  assign w_readRn[2] = rd_in_rn;
  assign w_readRn[3] = rd2_in_rn;

  sched_scoreboard #(
    .REG_BITS (REG_BITS),
    .NUM_WB   (NUM_WB)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_wbRn      (wb_rn),
    .i_wbValid   (wb_valid),
    .i_set0En    (w_willIssue & ~in_nodest & (rd_in_rn != '0)),
    .i_set0Rn    (rd_in_rn),
    .i_set1En    (w_willIssue & w_isAdv & (rd2_in_rn != '0)),
    .i_set1Rn    (rd2_in_rn),
    .i_readRn    (w_readRn),
    .o_busyEff   (w_busyEff),
    .o_busyCount (busy_count)
  );

  assign w_hazard = w_busyEff[0] | w_busyEff[1] | w_busyEff[2] |
                    (w_isAdv & w_busyEff[3]);

  assign w_unitFree = (w_isAlu & ~(&alu_busy)) |
                      (w_isAdv & ~advint_busy) |
                      (w_isMem & ~memunit_busy) |
                      (w_isBr  & ~branch_busy);

  assign w_startup   = (r_startCnt != 4'd0);
  assign w_willIssue = in_valid & ~flush & ~w_startup & ~w_hazard & w_unitFree;
  assign will_issue  = w_willIssue;

`ifdef SCHED_RR_EN
  localparam int PTR_W = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;

  logic [PTR_W-1:0] r_rrPtr;
  logic [PTR_W-1:0] w_rrPtrNext;
  logic             w_found;
  int               w_rrIdx;

  // r_rrPtr holds the index where the next search begins, i.e. one past
  // the ALU that issued last.
  always_comb begin
    w_aluSel    = '0;
    w_found     = 1'b0;
    w_rrIdx     = 0;
    w_rrPtrNext = r_rrPtr;
    for (int k = 0; k < NUM_ALU; k++) begin
      w_rrIdx = (int'(r_rrPtr) + k) % NUM_ALU;
      if (!w_found && !alu_busy[w_rrIdx]) begin
        w_found           = 1'b1;
        w_aluSel[w_rrIdx] = 1'b1;
        w_rrPtrNext       = PTR_W'((w_rrIdx + 1) % NUM_ALU);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rrPtr <= '0;
    end else if (w_willIssue && w_isAlu) begin
      r_rrPtr <= w_rrPtrNext;
    end
  end
`else
  always_comb begin
    w_aluSel = '0;
    for (int k = NUM_ALU - 1; k >= 0; k--) begin
      if (!alu_busy[k]) begin
        w_aluSel    = '0;
        w_aluSel[k] = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_startCnt <= 4'(STARTUP_STALL);
    end else if (w_startup) begin
      r_startCnt <= r_startCnt - 4'd1;
    end
  end

  // Enables and destinations are single-cycle pulses; anything not issued
  // this cycle drops back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aluEn  <= '0;
      r_advEn  <= 1'b0;
      r_memEn  <= 1'b0;
      r_brEn   <= 1'b0;
      r_rdOut  <= '0;
      r_rd2Out <= '0;
    end else begin
      r_aluEn  <= (w_willIssue && w_isAlu) ? w_aluSel : '0;
      r_advEn  <= w_willIssue & w_isAdv;
      r_memEn  <= w_willIssue & w_isMem;
      r_brEn   <= w_willIssue & w_isBr;
      r_rdOut  <= w_willIssue ? rd_in_rn : '0;
      r_rd2Out <= (w_willIssue && w_isAdv) ? rd2_in_rn : '0;
    end
  end

  assign alu_en     = r_aluEn;
  assign advint_en  = r_advEn;
  assign memunit_en = r_memEn;
  assign branch_en  = r_brEn;
  assign rd_out_rn  = r_rdOut;
  assign rd2_out_rn = r_rd2Out;

endmodule

// File: tb/tb_schedule_multi.sv
// Scoreboard-driven bench for schedule_multi (NUM_ALU=3); honours SCHED_RR_EN.
module tb_schedule_multi;
  import sched_pkg::*;

  localparam int REG_BITS      = 6;
  localparam int NUM_ALU       = 3;
  localparam int NUM_WB        = 2;
  localparam int STARTUP_STALL = 2;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       in_valid;
  logic [1:0]                 in_class;
  logic                       in_nodest;
  logic [REG_BITS-1:0]        r1_in_rn, r2_in_rn, rd_in_rn, rd2_in_rn;
  logic                       will_issue;
  logic [NUM_WB*REG_BITS-1:0] wb_rn;
  logic [NUM_WB-1:0]          wb_valid;
  logic                       flush;
  logic [NUM_ALU-1:0]         alu_en;
  logic                       advint_en, memunit_en, branch_en;
  logic [NUM_ALU-1:0]         alu_busy;
  logic                       advint_busy, memunit_busy, branch_busy;
  logic [REG_BITS-1:0]        rd_out_rn, rd2_out_rn;
  logic [REG_BITS:0]          busy_count;

  typedef struct {
    logic [NUM_ALU-1:0]  aluEn;
    logic                advEn;
    logic                memEn;
    logic                brEn;
    logic [REG_BITS-1:0] rd;
    logic [REG_BITS-1:0] rd2;
    logic [REG_BITS:0]   bc;
  } expOut_t;

  expOut_t expQ[$];
  int      checkCount = 0;
  int      passCount  = 0;
  bit      modelSb[64];
  int      modelStart = 0;
  int      modelPtr   = 0;

  schedule_multi #(
    .REG_BITS      (REG_BITS),
    .NUM_ALU       (NUM_ALU),
    .NUM_WB        (NUM_WB),
    .STARTUP_STALL (STARTUP_STALL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_class     (in_class),
    .in_nodest    (in_nodest),
    .r1_in_rn     (r1_in_rn),
    .r2_in_rn     (r2_in_rn),
    .rd_in_rn     (rd_in_rn),
    .rd2_in_rn    (rd2_in_rn),
    .will_issue   (will_issue),
    .wb_rn        (wb_rn),
    .wb_valid     (wb_valid),
    .flush        (flush),
    .alu_en       (alu_en),
    .advint_en    (advint_en),
    .memunit_en   (memunit_en),
    .branch_en    (branch_en),
    .alu_busy     (alu_busy),
    .advint_busy  (advint_busy),
    .memunit_busy (memunit_busy),
    .branch_busy  (branch_busy),
    .rd_out_rn    (rd_out_rn),
    .rd2_out_rn   (rd2_out_rn),
    .busy_count   (busy_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
               tag, actual, expected, $time);
    end
  endtask

  function automatic bit modelBusy(input int r);
    bit hit;
    hit = 1'b0;
    for (int p = 0; p < NUM_WB; p++) begin
      if (wb_valid[p] && (int'(wb_rn[p*REG_BITS +: REG_BITS]) == r)) hit = 1'b1;
    end
    return (r != 0) && modelSb[r] && !hit;
  endfunction

  task automatic idle();
    in_valid     = 1'b0;
    in_class     = 2'd0;
    in_nodest    = 1'b0;
    r1_in_rn     = '0;
    r2_in_rn     = '0;
    rd_in_rn     = '0;
    rd2_in_rn    = '0;
    wb_rn        = '0;
    wb_valid     = '0;
    flush        = 1'b0;
    alu_busy     = '0;
    advint_busy  = 1'b0;
    memunit_busy = 1'b0;
    branch_busy  = 1'b0;
  endtask

  task automatic setOp(input logic [1:0] cls, input logic nd,
                       input int r1, input int r2, input int rd, input int rd2);
    in_valid  = 1'b1;
    in_class  = cls;
    in_nodest = nd;
    r1_in_rn  = REG_BITS'(r1);
    r2_in_rn  = REG_BITS'(r2);
    rd_in_rn  = REG_BITS'(rd);
    rd2_in_rn = REG_BITS'(rd2);
  endtask

  // One clock: predict, push the registered outcome, step, pop and compare.
  task automatic applyStimulus();
    expOut_t e, got;
    bit      hazard, unitFree, expWill;
    int      sel, cnt;
    #1;
    e = '{default: '0};
    if (rst) begin
      for (int r = 0; r < 64; r++) modelSb[r] = 1'b0;
      modelStart = STARTUP_STALL;
      modelPtr   = 0;
    end else begin
      hazard = modelBusy(int'(r1_in_rn)) || modelBusy(int'(r2_in_rn)) ||
               modelBusy(int'(rd_in_rn)) ||
               (in_class == 2'd1 && modelBusy(int'(rd2_in_rn)));
      case (in_class)
        2'd0:    unitFree = (alu_busy != '1);
        2'd1:    unitFree = !advint_busy;
        2'd2:    unitFree = !memunit_busy;
        default: unitFree = !branch_busy;
      endcase
      expWill = in_valid && !flush && (modelStart == 0) && !hazard && unitFree;
      checkOutput("will_issue", {63'd0, will_issue}, {63'd0, expWill});
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_valid[p]) modelSb[int'(wb_rn[p*REG_BITS +: REG_BITS])] = 1'b0;
      end
      if (expWill) begin
        e.rd = rd_in_rn;
        case (in_class)
          2'd0: begin
            sel = -1;
`ifdef SCHED_RR_EN
            for (int k = 0; k < NUM_ALU; k++) begin
              if (sel < 0 && !alu_busy[(modelPtr + k) % NUM_ALU]) sel = (modelPtr + k) % NUM_ALU;
            end
            modelPtr = (sel + 1) % NUM_ALU;
`else
            for (int k = 0; k < NUM_ALU; k++) begin
              if (sel < 0 && !alu_busy[k]) sel = k;
            end
`endif
            e.aluEn[sel] = 1'b1;
          end
          2'd1: begin
            e.advEn = 1'b1;
            e.rd2   = rd2_in_rn;
            if (rd2_in_rn != 0) modelSb[int'(rd2_in_rn)] = 1'b1;
          end
          2'd2:    e.memEn = 1'b1;
          default: e.brEn  = 1'b1;
        endcase
        if (!in_nodest && rd_in_rn != 0) modelSb[int'(rd_in_rn)] = 1'b1;
      end
      if (modelStart > 0) modelStart--;
    end
    cnt = 0;
    for (int r = 0; r < 64; r++) cnt += int'(modelSb[r]);
    e.bc = (REG_BITS+1)'(cnt);
    expQ.push_back(e);
    @(posedge clk);
    #1;
    got = expQ.pop_front();
    checkOutput("alu_en",     64'(alu_en),     64'(got.aluEn));
    checkOutput("advint_en",  64'(advint_en),  64'(got.advEn));
    checkOutput("memunit_en", 64'(memunit_en), 64'(got.memEn));
    checkOutput("branch_en",  64'(branch_en),  64'(got.brEn));
    checkOutput("rd_out_rn",  64'(rd_out_rn),  64'(got.rd));
    checkOutput("rd2_out_rn", 64'(rd2_out_rn), 64'(got.rd2));
    checkOutput("busy_count", 64'(busy_count), 64'(got.bc));
  endtask

  logic [NUM_ALU-1:0] expFree[4];
  logic [NUM_ALU-1:0] expOne[3];

  initial begin
`ifdef SCHED_RR_EN
    expFree = '{3'b001, 3'b010, 3'b100, 3'b001};
    expOne  = '{3'b010, 3'b100, 3'b010};
`else
    expFree = '{3'b001, 3'b001, 3'b001, 3'b001};
    expOne  = '{3'b010, 3'b010, 3'b010};
`endif
    idle();
    rst = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("reset_busy_count", 64'(busy_count), 64'd0);
    checkOutput("reset_alu_en", 64'(alu_en), 64'd0);

    // Startup stall then first issue.
    rst = 1'b0;
    setOp(2'd0, 1'b0, 1, 2, 3, 0);
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("startup_alu_en", 64'(alu_en), 64'd1);
    checkOutput("startup_rd_out", 64'(rd_out_rn), 64'd3);
    checkOutput("startup_busy_count", 64'(busy_count), 64'd1);

    // RAW stall and same-cycle write-back bypass.
    setOp(2'd0, 1'b0, 0, 0, 5, 0);
    applyStimulus();
    setOp(2'd0, 1'b0, 5, 0, 6, 0);
    applyStimulus();
    checkOutput("raw_stall_alu_en", 64'(alu_en), 64'd0);
    wb_valid = 2'b01;
    wb_rn    = {6'd0, 6'd5};
    applyStimulus();
    checkOutput("bypass_busy_count", 64'(busy_count), 64'd2);
    wb_valid = '0;

    // Set wins over clear of the same register.
    setOp(2'd0, 1'b0, 0, 0, 7, 0);
    wb_valid = 2'b10;
    wb_rn    = {6'd7, 6'd0};
    applyStimulus();
    checkOutput("set_over_clear_count", 64'(busy_count), 64'd3);
    wb_valid = '0;
    setOp(2'd0, 1'b0, 7, 0, 8, 0);
    applyStimulus();
    checkOutput("set_over_clear_stall", 64'(alu_en), 64'd0);

    // ADVINT dual destination, WAW on rd2, store without destination.
    setOp(2'd1, 1'b0, 0, 0, 10, 11);
    applyStimulus();
    checkOutput("advint_rd2_out", 64'(rd2_out_rn), 64'd11);
    checkOutput("advint_busy_count", 64'(busy_count), 64'd5);
    setOp(2'd1, 1'b0, 0, 0, 12, 11);
    applyStimulus();
    checkOutput("waw_rd2_stall", 64'(advint_en), 64'd0);
    setOp(2'd2, 1'b1, 0, 0, 12, 0);
    applyStimulus();
    checkOutput("store_memunit_en", 64'(memunit_en), 64'd1);
    checkOutput("store_busy_count", 64'(busy_count), 64'd5);
    setOp(2'd0, 1'b0, 12, 0, 0, 0);
    applyStimulus();
    advint_busy = 1'b1;
    setOp(2'd1, 1'b0, 0, 0, 20, 21);
    applyStimulus();
    advint_busy = 1'b0;
    branch_busy = 1'b1;
    setOp(2'd3, 1'b0, 0, 0, 0, 0);
    applyStimulus();
    branch_busy = 1'b0;
    applyStimulus();
    checkOutput("branch_en", 64'(branch_en), 64'd1);

    // Flush blocks issue but keeps the scoreboard; duplicate write-backs.
    flush = 1'b1;
    setOp(2'd0, 1'b0, 0, 0, 9, 0);
    applyStimulus();
    checkOutput("flush_alu_en", 64'(alu_en), 64'd0);
    checkOutput("flush_busy_count", 64'(busy_count), 64'd5);
    idle();
    wb_valid = 2'b11;
    wb_rn    = {6'd3, 6'd3};
    applyStimulus();
    checkOutput("dup_wb_busy_count", 64'(busy_count), 64'd4);

    // Reset mid-stream with four busy registers; stall restarts.
    idle();
    setOp(2'd0, 1'b0, 0, 0, 14, 0);
    rst = 1'b1;
    applyStimulus();
    checkOutput("midreset_busy_count", 64'(busy_count), 64'd0);
    rst = 1'b0;
    setOp(2'd2, 1'b0, 0, 0, 13, 0);
    applyStimulus();
    applyStimulus();
    checkOutput("restart_stall", 64'(memunit_en), 64'd0);
    applyStimulus();
    checkOutput("restart_memunit_en", 64'(memunit_en), 64'd1);

    // ALU pool selection.
    alu_busy = 3'b000;
    for (int i = 0; i < 4; i++) begin
      setOp(2'd0, 1'b0, 0, 0, 0, 0);
      applyStimulus();
      checkOutput($sformatf("alu_free_%0d", i), 64'(alu_en), 64'(expFree[i]));
    end
    alu_busy = 3'b001;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput($sformatf("alu_one_busy_%0d", i), 64'(alu_en), 64'(expOne[i]));
    end
    alu_busy = 3'b111;
    applyStimulus();
    checkOutput("alu_all_busy", 64'(alu_en), 64'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 80; i++) begin
      idle();
      rst = ($urandom_range(0, 39) == 0);
      setOp(2'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0),
            $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 15), $urandom_range(0, 15));
      in_valid     = ($urandom_range(0, 4) != 0);
      flush        = ($urandom_range(0, 9) == 0);
      alu_busy     = 3'($urandom_range(0, 7));
      advint_busy  = ($urandom_range(0, 3) == 0);
      memunit_busy = ($urandom_range(0, 3) == 0);
      branch_busy  = ($urandom_range(0, 3) == 0);
      wb_valid     = 2'($urandom_range(0, 3));
      wb_rn        = {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))};
      applyStimulus();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
